mem_arb_ctrl: RTL
=================

Name: mem_arb_ctrl

Overview:
- Parametrised successor to the two-port memory controller: arbitrates N_CH request channels (IF, LSB, future D-cache/prefetch) onto the byte-serial 8-bit memory bus.
- Serialises multi-byte little-endian reads and writes, stalls on I/O back-pressure, and supports per-channel read abort for ROB rollback.
- Sits between the requesting units and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- N_CH, 2, number of request channels; index 0 has the lowest round-robin index.
- ADDR_W, 32, address width.
- MAX_LEN, 4, maximum bytes per transfer; DATA_W = 8*MAX_LEN; LEN_W = clog2(MAX_LEN)+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- mem_din  in  8  read data byte, valid the cycle after its address
- mem_dout  out  8  write data byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full
- req_en  in  N_CH  per-channel request, level, held until done or abort
- req_wr  in  N_CH  per-channel 1 = write
- req_addr  in  N_CH*ADDR_W  per-channel start address
- req_len  in  N_CH*LEN_W  per-channel byte count, 1..MAX_LEN
- req_wdata  in  N_CH*DATA_W  per-channel write data, byte i in [8i+7:8i]
- req_abort  in  N_CH  per-channel read cancel (rollback)
- done  out  N_CH  one-cycle completion pulse, one-hot
- rdata  out  DATA_W  read data, zero-extended, valid with done

Behaviour:
- Reset (async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, done=0, rdata=0, byte counter=0, last_grant=N_CH-1.
- rdy low: no state or output register changes. mem_wr is forced to 0 combinationally while rdy is low.
- Idle behaviour: mem_wr=0 whenever no write byte is being driven. done deasserts the cycle after its pulse.

State machine: IDLE, READ, WRITE.
- IDLE
  - Round-robin grant to the first channel with req_en=1, searching upward from last_grant+1 with wrap-around.
  - Grant ignores any channel whose req_abort is high.
  - On the grant edge: latch ch, addr, len, wdata; set last_grant=ch.
  - Read grant: drive mem_a=addr, mem_wr=0, go to READ.
  - Write grant: drive mem_a=addr, mem_dout=byte0, mem_wr=1, go to WRITE.
- READ
  - Each edge k=1..len samples mem_din into rdata_buf byte k-1.
  - Edges k<len also drive mem_a=addr+k.
  - Edge len: done[ch]=1, rdata=buffer with upper bytes zeroed, go to IDLE.
  - Total: done visible len edges after the grant edge.
- WRITE
  - Edge k=1..len-1: drive mem_a=addr+k, mem_dout=byte k, mem_wr=1.
  - Edge len: mem_wr=0, done[ch]=1, go to IDLE.
- I/O stall
  - An address is I/O when mem_a[17:16]==2'b11.
  - A write byte to an I/O address is not driven while io_buffer_full=1: mem_wr=0, counter holds, and the byte is re-presented once io_buffer_full=0.
  - Stall cycles add directly to latency.
  - The byte counter advances only on accepted bytes.
- Abort
  - req_abort[ch] high during READ of ch: return to IDLE on that edge with mem_wr=0 and no done pulse.
  - Partially read bytes are discarded.
  - Abort never affects WRITE; committed stores always complete.
  - Abort on a non-granted channel has no effect.
- Bubble: IDLE is entered for at least one cycle between transfers. Back-to-back grants are therefore spaced len+1 edges apart.
- Simultaneous requests: only one grant per IDLE cycle. Others wait, with no starvation under round-robin.
- req_len=0 or >MAX_LEN: treated as MAX_LEN. Documented as illegal; the bench asserts it never occurs.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared macros header: state encodings, LEN_W computation, and the I/O address test macro (IO_HI = 2'b11 at [17:16]), alongside the existing width macros.
- One sub-module, rr_arbiter: N_CH-wide round-robin priority picker.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant and its index.
  - Purely combinational.
- The FSM and datapath stay in mem_arb_ctrl.

Test Plan:
- Read, ch0 wins:
  - Stimulus: ch0 read addr 0x100, len 4; memory bytes 11 22 33 44.
  - Response: mem_a 0x100..0x103 on consecutive cycles; done[0] 4 edges after grant; rdata=0x44332211.
- Round-robin contention:
  - Stimulus: ch0 and ch1 both request reads, len 1, and hold.
  - Response: grant order ch0, ch1, ch0; each done 2 edges apart plus bubble. Neither channel is served twice consecutively.
- I/O write stall:
  - Stimulus: ch1 write addr 0x30000, len 1, data 0x41; io_buffer_full high 3 cycles.
  - Response: mem_wr=0 for 3 cycles, then one cycle mem_wr=1, mem_dout=0x41; done[1] after.
- Rollback abort:
  - Stimulus: ch0 read len 4; req_abort[0] pulsed at edge 2.
  - Response: IDLE next cycle, no done[0]. A pending ch1 request is granted on the following edge.
  - Repeat with a write of len 4: the abort is ignored and done asserts normally.
- rdy / reset:
  - Stimulus: rdy low 5 cycles mid-read, len 2, addr 0x20.
  - Response: mem_a held, completion delayed exactly 5 cycles, rdata correct.
  - Stimulus: rst pulsed mid-write.
  - Response: all outputs 0 immediately; ch0 granted first after release.

Source files
------------

// File: rtl/mem_arb_ctrl_pkg.sv
// Shared types and helpers for the multi-channel byte-serial memory arbiter.
package mem_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [1:0] IO_HI = 2'b11;

  // Address bits [17:16] select the memory-mapped I/O window.
  function automatic logic is_io(input logic [1:0] hi);
    return hi == IO_HI;
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester above last_i, wrapping.
module mem_arb_ctrl_rr_arbiter #(
  parameter  int unsigned N_CH  = 2,
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned pos;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      pos = (32'(last_i) + off) % N_CH;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates N_CH request channels onto the byte-serial 8-bit memory bus,
// serialising little-endian transfers with I/O back-pressure and read abort.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
#(
  parameter  int unsigned N_CH    = 2,
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned MAX_LEN = 4,
  localparam int unsigned DATA_W  = 8 * MAX_LEN,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full,
  input  logic [N_CH-1:0]          req_en,
  input  logic [N_CH-1:0]          req_wr,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*LEN_W-1:0]    req_len,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  input  logic [N_CH-1:0]          req_abort,
  output logic [N_CH-1:0]          done,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e             state_q;
  logic [N_CH-1:0]    ch_oh_q;
  logic [IDX_W-1:0]   last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rbuf_q;
  logic [ADDR_W-1:0]  mem_a_q;
  logic [7:0]         mem_dout_q;
  logic               mem_wr_q;
  logic [N_CH-1:0]    done_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [N_CH-1:0]    gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len_raw;
  logic [LEN_W-1:0]   sel_len;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_wr;
  logic [LEN_W-1:0]   cnt_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               last_byte;
  logic [7:0]         wbyte_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               abort_c;

  mem_arb_ctrl_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i  (req_en & ~req_abort),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  // Out-of-range lengths collapse to a full-width transfer.
  always_comb begin
    sel_addr    = req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
    sel_len_raw = req_len[32'(gnt_idx) * LEN_W +: LEN_W];
    sel_wdata   = req_wdata[32'(gnt_idx) * DATA_W +: DATA_W];
    sel_wr      = req_wr[gnt_idx];
    sel_len     = (sel_len_raw == '0 || sel_len_raw > LEN_W'(MAX_LEN))
                  ? LEN_W'(MAX_LEN) : sel_len_raw;
  end

  // Next-byte address/data and the read buffer with the current byte merged in.
  always_comb begin
    cnt_d     = cnt_q + LEN_W'(1);
    addr_d    = addr_q + ADDR_W'(cnt_d);
    last_byte = (cnt_d == len_q);
    abort_c   = |(req_abort & ch_oh_q);
    wbyte_d   = '0;
    rdata_d   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      rdata_d[8*i +: 8] = (LEN_W'(i) == cnt_q) ? mem_din : rbuf_q[8*i +: 8];
      if (LEN_W'(i) == cnt_d) wbyte_d = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_oh_q    <= '0;
      last_q     <= IDX_W'(N_CH - 1);
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
    end else if (rdy) begin
      done_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          mem_wr_q <= 1'b0;
          if (|gnt) begin
            ch_oh_q <= gnt;
            last_q  <= gnt_idx;
            addr_q  <= sel_addr;
            len_q   <= sel_len;
            wdata_q <= sel_wdata;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            mem_a_q <= sel_addr;
            if (sel_wr) begin
              mem_dout_q <= sel_wdata[7:0];
              mem_wr_q   <= !(is_io(sel_addr[17:16]) && io_buffer_full);
              state_q    <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          mem_wr_q <= 1'b0;
          if (abort_c) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (last_byte) begin
            rdata_q <= rdata_d;
            done_q  <= ch_oh_q;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            rbuf_q  <= rdata_d;
            mem_a_q <= addr_d;
            cnt_q   <= cnt_d;
          end
        end
        ST_WRITE: begin
          // A byte counts as accepted only if it was actually driven last cycle.
          if (mem_wr_q) begin
            if (last_byte) begin
              mem_wr_q <= 1'b0;
              done_q   <= ch_oh_q;
              cnt_q    <= '0;
              state_q  <= ST_IDLE;
            end else begin
              cnt_q      <= cnt_d;
              mem_a_q    <= addr_d;
              mem_dout_q <= wbyte_d;
              mem_wr_q   <= !(is_io(addr_d[17:16]) && io_buffer_full);
            end
          end else begin
            mem_wr_q <= !(is_io(mem_a_q[17:16]) && io_buffer_full);
          end
        end
        default: begin
          mem_wr_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;
  assign done     = done_q;
  assign rdata    = rdata_q;

endmodule
